// File: rtl/sent_rx_pkg.sv
// Shared types and constants for the SENT RX output arbiter.
// Holds the FIFO word tags, requester indices, arbiter FSM states and the
// word packing helpers used when a grant captures requester data.
package sent_rx_pkg;

    localparam logic [1:0] TAG_FAST1  = 2'b00;
    localparam logic [1:0] TAG_FAST2  = 2'b01;
    localparam logic [1:0] TAG_SERIAL = 2'b10;
    // 2'b11 is reserved and never produced.

    localparam logic FAST   = 1'b0;
    localparam logic SERIAL = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_ACK   = 2'd2
    } arb_state_t;

    // Fast word: tag by channel, CRC status in bit 29, 12-bit data at the bottom.
    function automatic logic [31:0] pack_fast(input logic        ch,
                                              input logic        crc_ok,
                                              input logic [11:0] data);
        return {(ch ? TAG_FAST2 : TAG_FAST1), crc_ok, 17'd0, data};
    endfunction

    // Serial word: serial tag, message ID in [23:16], message data in [15:0].
    function automatic logic [31:0] pack_serial(input logic [7:0]  id,
                                                input logic [15:0] data);
        return {TAG_SERIAL, 6'd0, id, data};
    endfunction

endpackage

// File: rtl/sent_rx_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module sent_rx_sat_counter #(
    parameter int W = 8
) (
    input  logic         clk_rx,
    input  logic         reset_n_rx,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    logic [W-1:0] r_cnt;

    // Count up to all-ones and stick there until cleared.
    always_ff @(posedge clk_rx or negedge reset_n_rx) begin
        if (!reset_n_rx) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (inc && (r_cnt != {W{1'b1}})) begin
            r_cnt <= r_cnt + {{(W-1){1'b0}}, 1'b1};
        end
    end

    assign cnt = r_cnt;

endmodule

// File: rtl/sent_rx_out_arbiter.sv
// Round-robin arbiter sharing the RX FIFO write port between the fast-channel
// unpacker and the serial message decoder. Each grant produces one tagged
// 32-bit word; a request stalled on a full FIFO for too long is dropped.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | waiting for an eligible requester; grant and capture its word
// ST_WRITE | holding the captured word until the FIFO has room or timeout
// ST_ACK   | pulse the granted requester's ack, then back to idle
module sent_rx_out_arbiter
    import sent_rx_pkg::*;
#(
    parameter int FULL_TIMEOUT = 16,
    parameter int CNT_W        = 8
) (
    input  logic             clk_rx,
    input  logic             reset_n_rx,
    input  logic             enable_i,
    input  logic             clear_cnt_i,
    input  logic             fast_valid_i,
    input  logic             fast_ch_i,
    input  logic             fast_crc_ok_i,
    input  logic [11:0]      fast_data_i,
    output logic             fast_ack_o,
    input  logic             ser_valid_i,
    input  logic [7:0]       ser_id_i,
    input  logic [15:0]      ser_data_i,
    output logic             ser_ack_o,
    input  logic             fifo_full_i,
    output logic             wr_en_o,
    output logic [31:0]      wr_data_o,
    output logic             drop_o,
    output logic [CNT_W-1:0] drop_cnt_o,
    output logic [CNT_W-1:0] word_cnt_o
);

    localparam logic [7:0] WAIT_LAST = 8'(FULL_TIMEOUT - 1);

    arb_state_t  r_state;
    logic        r_last_grant;
    logic        r_grant;
    logic [7:0]  r_wait_cnt;
    logic [31:0] r_hold;
    logic [31:0] r_wr_data;
    logic        r_wr_en;
    logic        r_drop;
    logic        r_fast_ack;
    logic        r_ser_ack;

    logic        w_fast_elig;
    logic        w_ser_elig;
    logic        w_grant_sel;
    logic        w_write;
    logic        w_timeout_drop;

    // A requester whose ack is currently high has already been served; masking
    // it stops the same word from being granted a second time.
    assign w_fast_elig = fast_valid_i && !r_fast_ack && enable_i;
    assign w_ser_elig  = ser_valid_i  && !r_ser_ack  && enable_i;

    // On a tie the requester not served last wins; otherwise the only one asking.
    assign w_grant_sel = (w_fast_elig && w_ser_elig) ? ~r_last_grant : w_ser_elig;

    // The FIFO going non-full on the timeout cycle still counts as a write.
    assign w_write        = (r_state == ST_WRITE) && !fifo_full_i;
    assign w_timeout_drop = (r_state == ST_WRITE) && fifo_full_i && (r_wait_cnt == WAIT_LAST);

    // Arbiter FSM with registered strobes, acks and write data.
    always_ff @(posedge clk_rx or negedge reset_n_rx) begin
        if (!reset_n_rx) begin
            r_state      <= ST_IDLE;
            r_last_grant <= SERIAL;
            r_grant      <= FAST;
            r_wait_cnt   <= '0;
            r_hold       <= '0;
            r_wr_data    <= '0;
            r_wr_en      <= 1'b0;
            r_drop       <= 1'b0;
            r_fast_ack   <= 1'b0;
            r_ser_ack    <= 1'b0;
        end else begin
            r_wr_en    <= 1'b0;
            r_drop     <= 1'b0;
            r_fast_ack <= 1'b0;
            r_ser_ack  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_fast_elig || w_ser_elig) begin
                        r_grant      <= w_grant_sel;
                        r_last_grant <= w_grant_sel;
                        r_hold       <= (w_grant_sel == SERIAL)
                                        ? pack_serial(ser_id_i, ser_data_i)
                                        : pack_fast(fast_ch_i, fast_crc_ok_i, fast_data_i);
                        r_wait_cnt   <= '0;
                        r_state      <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (w_write) begin
                        r_wr_en   <= 1'b1;
                        r_wr_data <= r_hold;
                        r_state   <= ST_ACK;
                    end else if (w_timeout_drop) begin
                        r_drop  <= 1'b1;
                        r_state <= ST_ACK;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 8'd1;
                    end
                end
                ST_ACK: begin
                    if (r_grant == SERIAL) begin
                        r_ser_ack <= 1'b1;
                    end else begin
                        r_fast_ack <= 1'b1;
                    end
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    sent_rx_sat_counter #(.W(CNT_W)) u_word_cnt (
        .clk_rx     (clk_rx),
        .reset_n_rx (reset_n_rx),
        .inc        (w_write),
        .clr        (clear_cnt_i),
        .cnt        (word_cnt_o)
    );

    sent_rx_sat_counter #(.W(CNT_W)) u_drop_cnt (
        .clk_rx     (clk_rx),
        .reset_n_rx (reset_n_rx),
        .inc        (w_timeout_drop),
        .clr        (clear_cnt_i),
        .cnt        (drop_cnt_o)
    );

    assign fast_ack_o = r_fast_ack;
    assign ser_ack_o  = r_ser_ack;
    assign wr_en_o    = r_wr_en;
    assign wr_data_o  = r_wr_data;
    assign drop_o     = r_drop;

endmodule

// File: doc/sent_rx_out_arbiter.md
Name: sent_rx_out_arbiter

Overview:
Shares the single write port of the RX output FIFO between two requesters: the fast-channel unpacker (12-bit words, channel 1/2) and the serial/enhanced message decoder (8-bit ID + 16-bit data).
Each accepted request becomes one tagged 32-bit FIFO word.
Arbitration is round-robin. Back-pressure comes from fifo_full_i; a request blocked too long is dropped and counted.
Sits between the SENT RX control/decode logic and the RX FIFO.

Parameters:
FULL_TIMEOUT, 16, number of consecutive full cycles in WRITE before the pending request is dropped (range 1..255).
CNT_W, 8, width of the saturating drop and word counters.

Ports:
clk_rx  in  1  receive clock
reset_n_rx  in  1  asynchronous active-low reset
enable_i  in  1  high: new grants allowed
clear_cnt_i  in  1  synchronous clear of both counters
fast_valid_i  in  1  fast word pending; held until fast_ack_o
fast_ch_i  in  1  0 = fast channel 1, 1 = fast channel 2
fast_crc_ok_i  in  1  CRC status of the frame that carried the word
fast_data_i  in  12  fast-channel data
fast_ack_o  out  1  one-cycle pulse: fast request consumed (written or dropped)
ser_valid_i  in  1  serial message pending; held until ser_ack_o
ser_id_i  in  8  message ID
ser_data_i  in  16  message data
ser_ack_o  out  1  one-cycle pulse: serial request consumed
fifo_full_i  in  1  RX FIFO full
wr_en_o  out  1  one-cycle FIFO write strobe
wr_data_o  out  32  packed FIFO word
drop_o  out  1  one-cycle pulse when a request is dropped
drop_cnt_o  out  CNT_W  saturating count of dropped requests
word_cnt_o  out  CNT_W  saturating count of written words

Behaviour:
- Reset: all outputs 0, FSM in IDLE, last_grant = SERIAL (so the first tie goes to FAST), wait_cnt = 0. Reset mid-operation aborts the pending request with no ack.
- Packing (fixed):
  - Fast word: [31:30] = {0, fast_ch_i}, [29] = fast_crc_ok_i, [28:12] = 0, [11:0] = data.
  - Serial word: [31:30] = 2'b10, [29:24] = 0, [23:16] = ID, [15:0] = data.
  - Tag 2'b11 is reserved.
  - Data is captured into a holding register at grant; later changes on the inputs are ignored.
- FSM states: IDLE, WRITE, ACK.
- IDLE:
  - A requester is eligible when its valid is high, its ack_o is low, and enable_i is high.
  - One eligible requester: grant it.
  - Both eligible: grant the one that is not last_grant.
  - On grant: capture its data, update last_grant, clear wait_cnt, go to WRITE.
- WRITE, fifo_full_i = 0: pulse wr_en_o with wr_data_o = held word on the next cycle, increment word_cnt, go to ACK.
- WRITE, fifo_full_i = 1: increment wait_cnt.
  - When wait_cnt reaches FULL_TIMEOUT-1 and the FIFO is still full: no write, pulse drop_o, increment drop_cnt, go to ACK.
  - fifo_full_i deasserting on the timeout cycle itself counts as a write; the write wins.
- ACK: pulse the granted requester's ack_o for exactly one cycle, then return to IDLE. The requester updates or drops valid on the edge where it sees ack.
- The masking rule (ack_o high makes a requester ineligible) prevents a double grant of the same word.
- Latency: valid high in cycle 0 → WRITE in cycle 1 → wr_en_o in cycle 2 → ack in cycle 3. Best-case throughput is one word per 3 cycles.
- enable_i low: no new grants; a request already in WRITE/ACK completes normally.
- Counters:
  - Both saturate at all-ones.
  - clear_cnt_i zeroes both; if it coincides with an increment, clear wins.
  - Counter outputs are registered.
- wr_data_o holds its last value between writes.

Decomposition:
- Package sent_rx_pkg:
  - tag constants TAG_FAST1 = 2'b00, TAG_FAST2 = 2'b01, TAG_SERIAL = 2'b10.
  - FSM state enum.
  - requester index constants FAST = 0, SERIAL = 1.
- Sub-module sent_rx_sat_counter (parameter W; inputs inc, clr; output cnt), instantiated twice.

Test Plan:
- Single fast request, ch = 1, crc_ok = 1, data = 12'hABC, FIFO not full → wr_en_o in cycle 2 with wr_data_o = 32'h6000_0ABC, fast_ack_o in cycle 3, word_cnt_o = 1.
- Single serial request, ID = 8'h2A, data = 16'h1234 → wr_data_o = 32'h802A_1234, ser_ack_o one pulse.
- Both valid continuously after reset → writes alternate FAST, SERIAL, FAST, SERIAL; no requester is ever granted twice in a row.
- Fast request with fifo_full_i held high, FULL_TIMEOUT = 16 → no wr_en_o, drop_o pulse 16 cycles after entering WRITE, fast_ack_o, drop_cnt_o = 1.
- fifo_full_i deasserted exactly on the timeout cycle → word written, no drop; also 300 forced drops with CNT_W = 8 → drop_cnt_o saturates at 255.
- Assert reset_n_rx while in WRITE → all outputs 0 immediately, no ack; after release the pending valid is re-granted and written once.
